// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Purely declarative: no logic, no latency, no flow control.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_LSU   = 1'b1;

  localparam logic [31:0] RAM_BASE_DEFAULT = 32'h1001_0000;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin pick: one-hot grant, combinational (zero latency).
// No backpressure; a tie goes to the port that did not win last.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_req0 && i_req1) begin
      o_gnt = (i_last == REQ_FETCH) ? 2'b10 : 2'b01;
    end else if (i_req0) begin
      o_gnt = 2'b01;
    end else if (i_req1) begin
      o_gnt = 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer sharing one memory port: Gnt at N+1, Rvalid at N+2; requests wait, never drop.
// Optional address check (Err*_o ports) enabled by MEM_ARB_ADDR_CHECK_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 64,
  parameter int          DATA_WIDTH   = 32,
  parameter logic [31:0] RAM_BASE     = RAM_BASE_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Req0_i,
  input  logic                  Req1_i,
  input  logic [31:0]           Addr0_i,
  input  logic [31:0]           Addr1_i,
  input  logic                  We0_i,
  input  logic                  We1_i,
  input  logic [DATA_WIDTH-1:0] Wdata0_i,
  input  logic [DATA_WIDTH-1:0] Wdata1_i,
  output logic                  Gnt0_o,
  output logic                  Gnt1_o,
  output logic                  Rvalid0_o,
  output logic                  Rvalid1_o,
  output logic [DATA_WIDTH-1:0] Rdata_o,
`ifdef MEM_ARB_ADDR_CHECK_EN
  output logic                  Err0_o,
  output logic                  Err1_o,
`endif
  output logic [31:0]           Mem_Address_o,
  output logic [DATA_WIDTH-1:0] Mem_Write_Data_o,
  output logic                  Mem_Write_Enable_o,
  input  logic [DATA_WIDTH-1:0] Mem_Read_Data_i
);

  // The RAM window must sit above the ROM window or the decode overlaps.
  if (RAM_BASE < 32'(4 * MEMORY_DEPTH)) begin : g_cfg_check
    $error("mem_port_arbiter: RAM_BASE overlaps the ROM window");
  end

  arb_state_t            r_state;
  arb_state_t            w_next;
  logic                  r_winner;
  logic [31:0]           r_addr;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_last;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            w_gnt;
  logic                  w_arb_win;
  logic                  w_err;

  rr_arbiter2 u_rr (
    .i_req0 (Req0_i),
    .i_req1 (Req1_i),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  // Only IDLE and RESP may start a new access.
  assign w_arb_win = ((r_state == IDLE) || (r_state == RESP)) && (|w_gnt);

`ifdef MEM_ARB_ADDR_CHECK_EN
  localparam logic [32:0] ROM_END = 33'(4 * MEMORY_DEPTH);
  localparam logic [32:0] RAM_END = {1'b0, RAM_BASE} + 33'(4 * MEMORY_DEPTH);
  logic r_err;

  assign w_err = (r_state == ACCESS) &&
                 ((r_addr[1:0] != 2'b00) ||
                  (r_we && (r_addr < RAM_BASE)) ||
                  ({1'b0, r_addr} >= RAM_END) ||
                  (!r_we && ({1'b0, r_addr} >= ROM_END) && (r_addr < RAM_BASE)));
`else
  assign w_err = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_winner <= REQ_FETCH;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_last   <= REQ_LSU;
      r_data   <= '0;
`ifdef MEM_ARB_ADDR_CHECK_EN
      r_err    <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_arb_win) begin
        r_winner <= w_gnt[1];
        r_addr   <= w_gnt[1] ? Addr1_i  : Addr0_i;
        r_we     <= w_gnt[1] ? We1_i    : We0_i;
        r_wdata  <= w_gnt[1] ? Wdata1_i : Wdata0_i;
      end
      if (r_state == ACCESS) begin
        r_last <= r_winner;
        r_data <= (r_we || w_err) ? '0 : Mem_Read_Data_i;
`ifdef MEM_ARB_ADDR_CHECK_EN
        r_err  <= w_err;
`endif
      end
    end
  end

  always_comb begin
    w_next             = r_state;
    Gnt0_o             = 1'b0;
    Gnt1_o             = 1'b0;
    Rvalid0_o          = 1'b0;
    Rvalid1_o          = 1'b0;
    Rdata_o            = '0;
`ifdef MEM_ARB_ADDR_CHECK_EN
    Err0_o             = 1'b0;
    Err1_o             = 1'b0;
`endif
    Mem_Address_o      = '0;
    Mem_Write_Data_o   = '0;
    Mem_Write_Enable_o = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arb_win) w_next = ACCESS;
      end
      ACCESS: begin
        Gnt0_o             = (r_winner == REQ_FETCH);
        Gnt1_o             = (r_winner == REQ_LSU);
        Mem_Address_o      = r_addr;
        Mem_Write_Data_o   = r_wdata;
        Mem_Write_Enable_o = r_we & ~w_err;
        w_next             = RESP;
      end
      RESP: begin
        Rvalid0_o = (r_winner == REQ_FETCH);
        Rvalid1_o = (r_winner == REQ_LSU);
        Rdata_o   = r_data;
`ifdef MEM_ARB_ADDR_CHECK_EN
        Err0_o    = r_err && (r_winner == REQ_FETCH);
        Err1_o    = r_err && (r_winner == REQ_LSU);
`endif
        w_next    = w_arb_win ? ACCESS : IDLE;
      end
      default: w_next = IDLE;
    endcase
    // Reset kills the in-flight access combinationally, including the write strobe.
    if (RST) begin
      w_next             = IDLE;
      Gnt0_o             = 1'b0;
      Gnt1_o             = 1'b0;
      Rvalid0_o          = 1'b0;
      Rvalid1_o          = 1'b0;
      Rdata_o            = '0;
`ifdef MEM_ARB_ADDR_CHECK_EN
      Err0_o             = 1'b0;
      Err1_o             = 1'b0;
`endif
      Mem_Address_o      = '0;
      Mem_Write_Data_o   = '0;
      Mem_Write_Enable_o = 1'b0;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter and sequencer in front of `Memory_System`. It shares the single memory port between requester 0 (instruction fetch) and requester 1 (load/store). It grants requesters in round-robin order and drives the address, write data and write enable for exactly one access cycle. It registers the read data and returns it with a one-cycle valid pulse to the granted requester.

## Interface
- `MEMORY_DEPTH`, 64, words per memory (ROM and RAM each); used by the address check.
- `DATA_WIDTH`, 32, data word width.
- `RAM_BASE`, 32'h1001_0000, first RAM byte address; addresses below it are ROM.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `Req0_i`, `Req1_i` in 1 each: access request. Held with its payload until the matching grant.
- `Addr0_i`, `Addr1_i` in 32 each: byte address.
- `We0_i`, `We1_i` in 1 each: 1 = write, 0 = read.
- `Wdata0_i`, `Wdata1_i` in DATA_WIDTH each: write data.
- `Gnt0_o`, `Gnt1_o` out 1 each: one-cycle pulse. The request is consumed at the end of this cycle.
- `Rvalid0_o`, `Rvalid1_o` out 1 each: one-cycle response pulse.
- `Rdata_o` out DATA_WIDTH: response data, shared by both ports and qualified by `Rvalid*`.
- `Err0_o`, `Err1_o` out 1 each: error flag, qualified by `Rvalid*`. Present only with the macro.
- `Mem_Address_o` out 32: drives `Address_i`.
- `Mem_Write_Data_o` out DATA_WIDTH: drives `Write_Data`.
- `Mem_Write_Enable_o` out 1: drives `Write_Enable_i`.
- `Mem_Read_Data_i` in DATA_WIDTH: from `Read_Data` (combinational read path).

## Operation
- States: `IDLE`, `ACCESS`, `RESP`. Reset state is `IDLE`.
- **IDLE**
  - No request: stay in `IDLE`.
  - Any request: latch the winner's index, address, we and wdata, then go to `ACCESS`.
- **ACCESS** (one cycle)
  - Assert the winner's `Gnt` and drive `Mem_Address_o` and `Mem_Write_Data_o` from the latched payload.
  - `Mem_Write_Enable_o = latched_we & ~RST & ~err`.
  - Capture `Mem_Read_Data_i` into the data register. For a write, capture 0 instead.
  - Next state is `RESP`.
- **RESP** (one cycle)
  - Assert the winner's `Rvalid`; `Rdata_o` carries the captured data.
  - Arbitrate as in `IDLE`: a pending request goes directly to `ACCESS`, otherwise return to `IDLE`.
- **Round-robin rule**
  - `last` pointer resets to 1, so port 0 wins the first tie.
  - When both ports request, the port other than `last` wins.
  - `last` updates to the winner when that port's `Gnt` is asserted.
- **Idle memory drive:** outside `ACCESS`, the `Mem_*` outputs are 0 and `Mem_Write_Enable_o` is 0.
- **Request during ACCESS/RESP:** a request that arrives then waits; no request is ever dropped.
- **Mid-operation reset:** `RST` in any state returns the FSM to `IDLE` at that edge and drops the in-flight access.
  - No `Gnt`/`Rvalid` is issued for the dropped access.
  - The write enable is gated combinationally, so a write does not occur at the reset edge.
- **Reset values:** every output is 0, `last` = 1, data register = 0.

## Timing
- Request sampled at edge N (in `IDLE`) → `Gnt` and memory access in cycle N+1 → `Rvalid`/`Rdata` in cycle N+2.
- Read latency is 2 cycles from the first request cycle.
- Sustained throughput: one access per 2 cycles when both ports keep requesting. The ports alternate.
- A requester drops or changes `Req`/payload only in the cycle after its `Gnt`.
- `Gnt0_o` and `Gnt1_o` are never high together; the same holds for `Rvalid0_o` and `Rvalid1_o`.

## Configuration
- Macro: `MEM_ARB_ADDR_CHECK_EN`.
- **Defined:** in `ACCESS`, `err` is set when any of these holds:
  - `Addr[1:0] != 0`;
  - a write has `Addr < RAM_BASE`;
  - `Addr >= RAM_BASE + 4*MEMORY_DEPTH`;
  - a read has `4*MEMORY_DEPTH <= Addr < RAM_BASE`.
- **On error:** the write is suppressed, `Rdata_o` is 0, and `Err*_o` = 1 with the matching `Rvalid`.
- **Undefined:** `Err*_o` ports are absent, no check is made, and every access is passed through unchanged.

## Structure
- Package `mem_arb_pkg` holds:
  - state enum `arb_state_t` (`IDLE`, `ACCESS`, `RESP`);
  - requester index constants `REQ_FETCH` = 0, `REQ_LSU` = 1;
  - default `RAM_BASE`.
- One sub-module, `rr_arbiter2`: two requests plus `last` in, one-hot grant out, combinational. The FSM, payload latch and data register stay in the top level.

## Test plan
- **Single read:** `Req0_i` = 1, `Addr0_i` = 32'h0000_0008 → `Gnt0_o` in cycle 1, `Mem_Address_o` = 8; `Rvalid0_o` in cycle 2 with `Rdata_o` = ROM word 2.
- **Write then read:** port 1 writes 32'hDEAD_BEEF to 32'h1001_0004, then reads it → `Mem_Write_Enable_o` high for one cycle; the read returns 32'hDEAD_BEEF on `Rvalid1_o`.
- **Contention:** both ports hold requests for 8 cycles → grant order 0, 1, 0, 1; one `Rvalid` every 2 cycles; never two grants in one cycle.
- **Reset in ACCESS:** port 1 write to 32'h1001_0000 with `RST` asserted in the `ACCESS` cycle → no write (a later read returns the old value); no `Gnt1_o`/`Rvalid1_o`; all outputs 0 the next cycle.
- **Check (macro defined), ROM write:** port 1 write to 32'h0000_0010 → `Mem_Write_Enable_o` stays 0; `Rvalid1_o` with `Err1_o` = 1 and `Rdata_o` = 0.
- **Check (macro defined), misaligned read:** port 0 read of 32'h1001_0002 → `Err0_o` = 1.
